// File: rtl/fir_serial_io.sv
// Bit-serial I/O bridge for the FIR core: a TDM deserialiser on the RX side, and a FIFO-buffered serialiser on the TX side.
// Defining FIR_SERIAL_IO_PARITY_EN adds an even parity bit to every RX and TX frame; the default build has no parity.
module fir_serial_io #(
  parameter int DATA_WIDTH = 24,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b0,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_rx_word,
  output logic [CH_W-1:0]       o_rx_chan,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  input  logic [DATA_WIDTH-1:0] i_tx_word,
  input  logic [CH_W-1:0]       i_tx_chan,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic                  o_dout,
  output logic                  o_dout_valid,
  input  logic                  i_ready,
  output logic                  o_err
);

`ifdef FIR_SERIAL_IO_PARITY_EN
  localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
  localparam int FRAME_BITS = DATA_WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_HOLD}  rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_OFFER, TX_SHIFT} tx_state_t;

  rx_state_t             rx_state, rx_state_nxt;
  logic [CNT_W-1:0]      rx_cnt;
  logic [DATA_WIDTH-1:0] rx_sr, rx_sr_nxt;
  logic [CH_W-1:0]       chan_cnt;
  logic                  run, rx_start, rx_abort, rx_last, par_ok;

  // The channel tag travels with the result only for upstream ordering; it is not serialised.
  logic unused_tx_chan;
  assign unused_tx_chan = ^i_tx_chan;

  // ---------------- RX ----------------
  assign rx_sr_nxt = MSB_FIRST ? {rx_sr[DATA_WIDTH-2:0], i_din} : {i_din, rx_sr[DATA_WIDTH-1:1]};
  assign o_ready   = run & (rx_state == RX_IDLE) & i_en & ~o_rx_valid;
  assign rx_start  = o_ready & i_din_valid;
  assign rx_abort  = (rx_state == RX_SHIFT) & ~i_din_valid;
  assign rx_last   = (rx_state == RX_SHIFT) & i_din_valid & (rx_cnt == CNT_W'(FRAME_BITS - 1));
`ifdef FIR_SERIAL_IO_PARITY_EN
  assign par_ok = ((^rx_sr) == i_din);
`else
  assign par_ok = 1'b1;
`endif

  // NOTE: clocked processes use non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rx_state <= RX_IDLE;
    else       rx_state <= rx_state_nxt;
  end

  // NOTE: the default assignment at the top prevents a latch on paths that leave the state unchanged.
  always_comb begin
    rx_state_nxt = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_start) rx_state_nxt = RX_SHIFT;
      RX_SHIFT: if (rx_abort) rx_state_nxt = RX_IDLE;
                else if (rx_last) rx_state_nxt = par_ok ? RX_HOLD : RX_IDLE;
      RX_HOLD:  if (i_rx_ready) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    o_rx_valid = (rx_state == RX_HOLD);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run       <= 1'b0;
      rx_cnt    <= '0;
      rx_sr     <= '0;
      o_rx_word <= '0;
      o_rx_chan <= '0;
      chan_cnt  <= '0;
      o_err     <= 1'b0;
    end else begin
      run   <= 1'b1;
      o_err <= rx_abort | (rx_last & ~par_ok);
      if (rx_start) begin
        rx_sr  <= rx_sr_nxt;
        rx_cnt <= CNT_W'(1);
      end else if ((rx_state == RX_SHIFT) && i_din_valid) begin
        if (rx_cnt < CNT_W'(DATA_WIDTH)) rx_sr <= rx_sr_nxt;
        rx_cnt <= rx_cnt + 1'b1;
      end
      // A parity-failed frame still consumes its TDM slot.
      if (rx_last) begin
        if (par_ok) begin
`ifdef FIR_SERIAL_IO_PARITY_EN
          o_rx_word <= rx_sr;
`else
          o_rx_word <= rx_sr_nxt;
`endif
          o_rx_chan <= chan_cnt;
        end
        chan_cnt <= (chan_cnt == CH_W'(CHANNELS - 1)) ? '0 : chan_cnt + 1'b1;
      end
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        fifo_cnt;
  logic                  push, pop, fifo_empty;
  logic [DATA_WIDTH-1:0] tx_head;
  tx_state_t             tx_state, tx_state_nxt;

  assign o_tx_ready = (fifo_cnt != (PTR_W + 1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = i_tx_valid & o_tx_ready;
  assign pop        = (tx_state == TX_OFFER) & i_ready;
  assign tx_head    = fifo_mem[rd_ptr];

  // NOTE: storage needs no reset; only pointers and count define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_tx_word;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- TX serialiser ----------------
  logic [CNT_W-1:0]      tx_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic                  tx_bit;
`ifdef FIR_SERIAL_IO_PARITY_EN
  logic                  tx_par;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (!fifo_empty) tx_state_nxt = TX_OFFER;
      TX_OFFER: if (i_ready) tx_state_nxt = TX_SHIFT;
      TX_SHIFT: if (tx_cnt == CNT_W'(FRAME_BITS)) tx_state_nxt = TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    o_dout_valid = (tx_state != TX_IDLE);
  end

  always_comb begin
    tx_bit = MSB_FIRST ? tx_sr[DATA_WIDTH-1] : tx_sr[0];
`ifdef FIR_SERIAL_IO_PARITY_EN
    if (tx_cnt == CNT_W'(DATA_WIDTH)) tx_bit = tx_par;
`endif
  end

  // o_dout is registered: bit k appears in the k-th cycle after the handshake edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dout <= 1'b0;
      tx_sr  <= '0;
      tx_cnt <= '0;
`ifdef FIR_SERIAL_IO_PARITY_EN
      tx_par <= 1'b0;
`endif
    end else if (pop) begin
      o_dout <= MSB_FIRST ? tx_head[DATA_WIDTH-1] : tx_head[0];
      tx_sr  <= MSB_FIRST ? (tx_head << 1) : (tx_head >> 1);
      tx_cnt <= CNT_W'(1);
`ifdef FIR_SERIAL_IO_PARITY_EN
      tx_par <= ^tx_head;
`endif
    end else if (tx_state == TX_SHIFT) begin
      if (tx_cnt == CNT_W'(FRAME_BITS)) begin
        o_dout <= 1'b0;
      end else begin
        o_dout <= tx_bit;
        tx_sr  <= MSB_FIRST ? (tx_sr << 1) : (tx_sr >> 1);
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/fir_serial_io.md
Name: fir_serial_io

Overview:
Parametrised bit-serial I/O bridge for the FIR datapath. It deserialises time-multiplexed multi-channel serial sample frames into parallel words with channel tags for the filter core. It also buffers parallel filter results in a small FIFO and serialises them back out under a ready/valid handshake. It generalises the single-channel, fixed-order serial port to N channels, selectable bit order and buffered output.

Parameters:
DATA_WIDTH, 24, bits per sample word (>=2)
CHANNELS, 2, TDM channels per serial stream (>=1); channel index width CH_W = max(1, $clog2(CHANNELS))
FIFO_DEPTH, 4, TX result FIFO entries (power of two, >=2)
MSB_FIRST, 0, 0 = LSB-first, 1 = MSB-first; applies to both RX and TX

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_en  in  1  enable; low blocks new RX frame starts (frames in progress complete)
i_din  in  1  serial input data
i_din_valid  in  1  serial input frame valid; must stay high for whole frame
o_ready  out  1  RX ready to start a new frame
o_rx_word  out  DATA_WIDTH  deserialised word to core
o_rx_chan  out  CH_W  channel tag of o_rx_word
o_rx_valid  out  1  o_rx_word valid
i_rx_ready  in  1  core accepts o_rx_word
i_tx_word  in  DATA_WIDTH  filter result from core
i_tx_chan  in  CH_W  channel tag of result
i_tx_valid  in  1  result valid
o_tx_ready  out  1  FIFO not full
o_dout  out  1  serial output data
o_dout_valid  out  1  serial output word available / in progress
i_ready  in  1  downstream ready to start receiving a TX frame
o_err  out  1  one-cycle pulse on RX frame abort (or parity error)

Behaviour:
- Reset: o_ready=0, o_rx_valid=0, o_rx_word=0, o_rx_chan=0, o_dout=0, o_dout_valid=0, o_err=0. FIFO empties. Channel counter=0. Both FSMs go to IDLE. Reset mid-frame discards the partial word.
- RX FSM IDLE/SHIFT/HOLD:
  - IDLE: o_ready = i_en & !o_rx_valid.
  - Start edge: first rising edge with i_din_valid & o_ready. Bit 0 (LSB, or MSB if MSB_FIRST) is sampled on that edge. Go to SHIFT; o_ready drops.
  - SHIFT: one bit per consecutive edge, DATA_WIDTH bits total.
  - i_din_valid low during SHIFT: discard partial word, pulse o_err, return to IDLE. Channel counter does not advance.
  - Last bit sampled: o_rx_word and o_rx_chan = channel counter, o_rx_valid=1 on the next cycle. Counter increments and wraps at CHANNELS-1 to 0. Go to HOLD.
  - HOLD: outputs stable until o_rx_valid & i_rx_ready, then o_rx_valid=0 and return to IDLE. o_ready can rise the cycle after acceptance.
- TX FIFO:
  - Push on i_tx_valid & o_tx_ready; pop on serializer load.
  - o_tx_ready = !full, with no full-bypass. Push and pop in the same cycle leave the count unchanged.
  - Overflow is impossible. A pop when empty never occurs.
- TX FSM IDLE/OFFER/SHIFT:
  - IDLE with FIFO non-empty: o_dout_valid=1 next cycle, go to OFFER.
  - OFFER: first edge with i_ready=1 pops the head word. o_dout carries bit 0 from that edge for one cycle; bit k is valid in the k-th cycle after the handshake edge.
  - o_dout_valid stays high through the last bit, then drops for at least 1 cycle before the next OFFER.
  - i_ready is sampled only in OFFER; deassertion during SHIFT is ignored.
  - The channel tag is not serialised; it is only used for ordering checks.
- Latency:
  - RX: last bit edge to o_rx_valid = 1 cycle.
  - TX: push to o_dout_valid = 2 cycles when idle and empty.
- Word order is FIFO order; there is no reordering by channel.

Optional Feature:
Macro FIR_SERIAL_IO_PARITY_EN.
- Defined:
  - RX frames carry DATA_WIDTH+1 bits; the final bit is even parity over the data.
  - On mismatch: word dropped, o_err pulses, channel counter still advances.
  - TX appends an even parity bit after the data bits; o_dout_valid spans DATA_WIDTH+1 bit cycles.
- Undefined: frames are exactly DATA_WIDTH bits, with no parity logic.

Test Plan:
- Reset, then one LSB-first RX frame 0x00ABCD on channel 0 with i_rx_ready=1 -> o_rx_word=0x00ABCD, o_rx_chan=0, o_rx_valid high 1 cycle, o_ready returns high.
- Three consecutive RX frames, CHANNELS=2 -> o_rx_chan sequence 0,1,0.
- i_din_valid dropped after 10 bits -> o_err one pulse, no o_rx_valid, next full frame tagged with the same channel.
- Push 4 words 0x000001..0x000004 with i_ready held low -> o_tx_ready low after the 4th. Raise i_ready -> serial words out in order, one-cycle gap between frames.
- MSB_FIRST=1, TX word 0x800001 -> o_dout bit sequence 1,0,…,0,1 over 24 cycles after the handshake edge.
- i_rst asserted mid TX frame -> o_dout_valid=0 and o_dout=0 immediately, FIFO empty, o_tx_ready=1 after release.
